i2s_tdm_tx: RTL and testbench

Parametrised single-clock serial audio transmitter, and successor to the two-domain `i2s_tx`. It generates BCLK, LRCLK and SDA from `clk_i` using an integer clock-enable divider. Sample width, slot width and channel count are parameters, and the frame format (I2S or left-justified) is selectable at run time. It sits between the synth/mixer sample path and the codec pins, and accepts one whole multi-channel frame per valid/ready handshake through a one-frame holding buffer.

---
 rtl/i2s_tdm_tx.sv | 163 ++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// Single-clock I2S / left-justified TDM transmitter with a one-frame holding buffer.
// Define I2S_TDM_TX_REPEAT_EN to resend the last frame on underrun instead of zeros.
module i2s_tdm_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int CHANNELS = 2,
  parameter int CLK_DIV  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         mode_i,
  input  logic [CHANNELS*SAMPLE_W-1:0] frame_i,
  input  logic                         frame_valid_i,
  output logic                         frame_ready_o,
  output logic                         underrun_o,
  output logic                         aud_bclk_o,
  output logic                         aud_lrclk_o,
  output logic                         aud_sda_o
);

  localparam int FB   = CHANNELS * SLOT_W;
  localparam int IN_W = CHANNELS * SAMPLE_W;
  localparam int BW   = $clog2(FB);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(FB / 2);

  logic [DW-1:0]   div_q;
  logic            bclk_q;
  logic [BW-1:0]   bit_q;
  logic            first_q;
  logic [FB-1:0]   shift_q;
  logic            dly_q;
  logic            lrclk_q;
  logic            mode_q;
  logic            underrun_q;
  logic [IN_W-1:0] hold_q;
  logic            hold_full_q;

  logic            div_wrap;
  logic            fall;
  logic            frame_end;
  logic            boundary;
  logic            accept;
  logic            mode_next;
  logic            lrclk_next;
  logic [BW-1:0]   bit_next;
  logic [IN_W-1:0] load_frame;
  logic [FB-1:0]   shift_next;

`ifdef I2S_TDM_TX_REPEAT_EN
  logic [IN_W-1:0] shadow_q;
`endif

  // Spread each sample into its slot, MSB-aligned, zero-padded below.
  function automatic logic [FB-1:0] format_frame(input logic [IN_W-1:0] f);
    logic [FB-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      r[FB-1-c*SLOT_W -: SAMPLE_W] = f[IN_W-1-c*SAMPLE_W -: SAMPLE_W];
    end
    return r;
  endfunction

  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    fall      = en_i && bclk_q && div_wrap;
    frame_end = first_q || (bit_q == BIT_LAST);
    boundary  = fall && frame_end;
    accept    = frame_valid_i && !hold_full_q;
    bit_next  = frame_end ? '0 : bit_q + 1'b1;
    mode_next = boundary ? mode_i : mode_q;
    // I2S leads the delayed data by one BCLK, so left ends up as the low half
    lrclk_next = mode_next ? (bit_next < BIT_HALF) : (bit_next >= BIT_HALF);
    if (hold_full_q) begin
      load_frame = hold_q;
    end else if (frame_valid_i) begin
      load_frame = frame_i;
    end else begin
`ifdef I2S_TDM_TX_REPEAT_EN
      load_frame = shadow_q;
`else
      load_frame = '0;
`endif
    end
    shift_next = boundary ? format_frame(load_frame) : {shift_q[FB-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (!en_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (div_wrap) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_q   <= '0;
      first_q <= 1'b1;
      shift_q <= '0;
      dly_q   <= 1'b0;
      lrclk_q <= 1'b0;
      mode_q  <= 1'b0;
    end else if (!en_i) begin
      bit_q   <= '0;
      first_q <= 1'b1;
      shift_q <= '0;
      dly_q   <= 1'b0;
      lrclk_q <= 1'b0;
    end else if (fall) begin
      bit_q   <= bit_next;
      first_q <= 1'b0;
      shift_q <= shift_next;
      dly_q   <= shift_q[FB-1];
      lrclk_q <= lrclk_next;
      mode_q  <= mode_next;
    end
  end

  // A frame offered in the boundary cycle with the buffer empty bypasses it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= boundary && !hold_full_q && !frame_valid_i;
      if (boundary && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (accept && !boundary) begin
        hold_q      <= frame_i;
        hold_full_q <= 1'b1;
      end
    end
  end

`ifdef I2S_TDM_TX_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (boundary && (hold_full_q || frame_valid_i)) begin
      shadow_q <= load_frame;
    end
  end
`endif

  assign frame_ready_o = !hold_full_q;
  assign underrun_o    = underrun_q;
  assign aud_bclk_o    = bclk_q;
  assign aud_lrclk_o   = lrclk_q;
  assign aud_sda_o     = mode_q ? shift_q[FB-1] : dly_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed self-checking bench for i2s_tdm_tx: a default 16/16/2 instance and
// a 16/24/4 TDM instance, checked slot by slot as sampled on BCLK rise.
module tb_i2s_tdm_tx;

`ifdef I2S_TDM_TX_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, valid;
  logic [31:0] frame;
  logic        ready, underrun, bclk, lrclk, sda;

  logic        en4, mode4, valid4;
  logic [63:0] frame4;
  logic        ready4, underrun4, bclk4, lrclk4, sda4;

  int          sel;
  logic        m_bclk, m_sda, m_lr, m_ready;

  int          checks = 0;
  int          passed = 0;
  int          ucnt = 0;

  logic        sda_s [0:255];
  logic        lr_s  [0:255];
  int          uc_s  [0:255];
  longint      t_s   [0:255];

  i2s_tdm_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .frame_i(frame), .frame_valid_i(valid), .frame_ready_o(ready),
    .underrun_o(underrun), .aud_bclk_o(bclk), .aud_lrclk_o(lrclk), .aud_sda_o(sda)
  );

  i2s_tdm_tx #(.SAMPLE_W(16), .SLOT_W(24), .CHANNELS(4), .CLK_DIV(3)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en4), .mode_i(mode4),
    .frame_i(frame4), .frame_valid_i(valid4), .frame_ready_o(ready4),
    .underrun_o(underrun4), .aud_bclk_o(bclk4), .aud_lrclk_o(lrclk4), .aud_sda_o(sda4)
  );

  always #5 clk = ~clk;

  assign m_bclk  = (sel == 1) ? bclk4  : bclk;
  assign m_sda   = (sel == 1) ? sda4   : sda;
  assign m_lr    = (sel == 1) ? lrclk4 : lrclk;
  assign m_ready = (sel == 1) ? ready4 : ready;

  always @(negedge clk) begin
    if (underrun === 1'b1) ucnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = m_bclk;
    ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_bclk && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = m_bclk;
    end
  endtask

  task automatic capture(input int n, input int toggle_at);
    bit ok;
    for (int s = 0; s < n; s++) begin
      wait_rise(ok);
      if (!ok) begin
        checks++;
        $display("FAIL bclk_timeout: no BCLK rise at slot %0d, required one within 100 cycles", s);
        break;
      end
      sda_s[s] = m_sda;
      lr_s[s]  = m_lr;
      uc_s[s]  = ucnt;
      t_s[s]   = longint'($time);
      if (s == toggle_at) mode = ~mode;
    end
  endtask

  task automatic push(input logic [63:0] f);
    bit done;
    done = 1'b0;
    if (sel == 1) begin frame4 = f; valid4 = 1'b1; end
    else begin frame = f[31:0]; valid = 1'b1; end
    for (int i = 0; i < 2000 && !done; i++) begin
      if (m_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    valid  = 1'b0;
    valid4 = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL push_timeout: frame %h not accepted, ready stayed 0", f);
    end
  endtask

  // Enable the selected instance and count clk cycles up to the first BCLK rise.
  task automatic enable_and_skip(output int n);
    if (sel == 1) en4 = 1'b1; else en = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (m_bclk) break;
    end
  endtask

  function automatic logic [95:0] get_bits(input int start, input int n, input bit use_lr);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[94:0], use_lr ? lr_s[start+i] : sda_s[start+i]};
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0; mode = 1'b0; valid = 1'b0; frame = '0;
    en4 = 1'b0; mode4 = 1'b0; valid4 = 1'b0; frame4 = '0;
    sel = 0;
    repeat (2) @(negedge clk);
    checks++; if (bclk !== 1'b0) $display("FAIL reset_bclk: got %b want 0", bclk); else passed++;
    checks++; if (lrclk !== 1'b0) $display("FAIL reset_lrclk: got %b want 0", lrclk); else passed++;
    checks++; if (sda !== 1'b0) $display("FAIL reset_sda: got %b want 0", sda); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i2s_stream;
    int n, base;
    logic [31:0] exp_w [0:5];
    logic [31:0] got;
    exp_w[0] = 32'h0001_0001;
    exp_w[1] = 32'h8000_8000;
    exp_w[2] = 32'hCAFE_FEED;
    for (int f = 3; f < 6; f++) exp_w[f] = REPEAT ? 32'hCAFE_FEED : 32'h0;
    sel = 0; mode = 1'b0;
    push(64'(exp_w[0]));
    checks++; if (ready !== 1'b0) $display("FAIL preload_ready: got %b want 0", ready); else passed++;
    base = ucnt;
    enable_and_skip(n);
    checks++; if (n != 2) $display("FAIL first_rise: got %0d cycles want 2", n); else passed++;
    fork
      capture(193, -1);
      begin
        push(64'(exp_w[1]));
        push(64'(exp_w[2]));
      end
    join
    checks++; if (t_s[5] - t_s[4] != 40) $display("FAIL bclk_period: got %0d ns want 40", t_s[5] - t_s[4]); else passed++;
    checks++; if (sda_s[0] !== 1'b0) $display("FAIL i2s_slot0: got %b want 0", sda_s[0]); else passed++;
    for (int f = 0; f < 6; f++) begin
      got = get_bits(32*f + 1, 32, 1'b0)[31:0];
      checks++;
      if (got !== exp_w[f]) $display("FAIL i2s_word%0d: got %h want %h", f, got, exp_w[f]);
      else passed++;
    end
    for (int f = 0; f < 3; f++) begin
      got = get_bits(32*f, 32, 1'b1)[31:0];
      checks++;
      if (got !== 32'h0000_FFFF) $display("FAIL i2s_lrclk%0d: got %h want 0000ffff", f, got);
      else passed++;
    end
    checks++; if (uc_s[95] - base != 0) $display("FAIL fed_underruns: got %0d want 0", uc_s[95] - base); else passed++;
    checks++; if (uc_s[191] - uc_s[95] != 3) $display("FAIL underrun_pulses: got %0d want 3", uc_s[191] - uc_s[95]); else passed++;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_left_justified;
    int n, base;
    logic [31:0] got;
    logic [31:0] rep;
    rep = REPEAT ? 32'h1234_5678 : 32'h0;
    sel = 0; mode = 1'b1;
    push(64'h0000_0000_CAFE_FEED);
    base = ucnt;
    enable_and_skip(n);
    fork
      capture(97, 40);
      push(64'h0000_0000_1234_5678);
    join
    got = get_bits(0, 32, 1'b0)[31:0];
    checks++; if (got !== 32'hCAFE_FEED) $display("FAIL lj_word0: got %h want cafefeed", got); else passed++;
    got = get_bits(32, 32, 1'b0)[31:0];
    checks++; if (got !== 32'h1234_5678) $display("FAIL lj_mode_midframe: got %h want 12345678", got); else passed++;
    got = get_bits(65, 32, 1'b0)[31:0];
    checks++; if (got !== rep) $display("FAIL lj_to_i2s_word: got %h want %h", got, rep); else passed++;
    got = get_bits(0, 32, 1'b1)[31:0];
    checks++; if (got !== 32'hFFFF_0000) $display("FAIL lj_lrclk0: got %h want ffff0000", got); else passed++;
    got = get_bits(32, 32, 1'b1)[31:0];
    checks++; if (got !== 32'hFFFF_0000) $display("FAIL lj_lrclk1: got %h want ffff0000", got); else passed++;
    got = get_bits(64, 32, 1'b1)[31:0];
    checks++; if (got !== 32'h0000_FFFF) $display("FAIL lj_lrclk_after_switch: got %h want 0000ffff", got); else passed++;
    checks++; if (uc_s[95] - base != 1) $display("FAIL lj_underrun: got %0d want 1", uc_s[95] - base); else passed++;
    mode = 1'b0;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tdm;
    int n;
    logic [95:0] got;
    sel = 1; mode4 = 1'b0;
    push(64'hFFFF_0000_AAAA_1234);
    enable_and_skip(n);
    checks++; if (n != 3) $display("FAIL tdm_first_rise: got %0d cycles want 3", n); else passed++;
    capture(97, -1);
    checks++; if (t_s[3] - t_s[2] != 60) $display("FAIL tdm_bclk_period: got %0d ns want 60", t_s[3] - t_s[2]); else passed++;
    got = get_bits(1, 96, 1'b0);
    checks++;
    if (got !== 96'hFFFF00_000000_AAAA00_123400) $display("FAIL tdm_data: got %h want ffff00000000aaaa00123400", got);
    else passed++;
    got = get_bits(0, 96, 1'b1);
    checks++;
    if (got !== {48'h0, 48'hFFFF_FFFF_FFFF}) $display("FAIL tdm_lrclk: got %h want 000000000000ffffffffffff", got);
    else passed++;
    en4 = 1'b0;
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int base;
    logic [31:0] got;
    sel = 0; mode = 1'b0;
    checks++; if (ready !== 1'b1) $display("FAIL bypass_start_ready: got %b want 1", ready); else passed++;
    base = ucnt;
    en = 1'b1;
    repeat (3) @(negedge clk);
    frame = 32'h5A5A_C3C3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ready !== 1'b1) $display("FAIL bypass_keeps_empty: got ready %b want 1", ready); else passed++;
    fork
      capture(97, -1);
      begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        push(64'h0000_0000_0F1E_2D3C);
        repeat ($urandom_range(0, 30)) @(negedge clk);
        push(64'h0000_0000_9988_7766);
      end
    join
    got = get_bits(1, 32, 1'b0)[31:0];
    checks++; if (got !== 32'h5A5A_C3C3) $display("FAIL bypass_word: got %h want 5a5ac3c3", got); else passed++;
    got = get_bits(33, 32, 1'b0)[31:0];
    checks++; if (got !== 32'h0F1E_2D3C) $display("FAIL gap_word1: got %h want 0f1e2d3c", got); else passed++;
    got = get_bits(65, 32, 1'b0)[31:0];
    checks++; if (got !== 32'h9988_7766) $display("FAIL gap_word2: got %h want 99887766", got); else passed++;
    checks++; if (uc_s[95] - base != 0) $display("FAIL bypass_underrun: got %0d want 0", uc_s[95] - base); else passed++;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_drop;
    int n;
    logic [31:0] got;
    sel = 0; mode = 1'b0;
    push(64'h0000_0000_FFFF_FFFF);
    en = 1'b1;
    repeat (40) @(negedge clk);
    push(64'h0000_0000_2468_ACE0);
    checks++; if (sda !== 1'b1) $display("FAIL drop_pre_sda: got %b want 1", sda); else passed++;
    en = 1'b0;
    @(negedge clk);
    checks++; if (bclk !== 1'b0) $display("FAIL drop_bclk: got %b want 0", bclk); else passed++;
    checks++; if (lrclk !== 1'b0) $display("FAIL drop_lrclk: got %b want 0", lrclk); else passed++;
    checks++; if (sda !== 1'b0) $display("FAIL drop_sda: got %b want 0", sda); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL drop_keeps_hold: got ready %b want 0", ready); else passed++;
    repeat (5) @(negedge clk);
    enable_and_skip(n);
    capture(33, -1);
    checks++; if (sda_s[0] !== 1'b0) $display("FAIL drop_delay_cleared: got %b want 0", sda_s[0]); else passed++;
    got = get_bits(1, 32, 1'b0)[31:0];
    checks++; if (got !== 32'h2468_ACE0) $display("FAIL drop_held_word: got %h want 2468ace0", got); else passed++;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    sel = 0; mode = 1'b0;
    push(64'h0000_0000_FFFF_FFFF);
    en = 1'b1;
    repeat (30) @(negedge clk);
    push(64'h0000_0000_2222_2222);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bclk !== 1'b0) $display("FAIL rst_mid_bclk: got %b want 0", bclk); else passed++;
    checks++; if (lrclk !== 1'b0) $display("FAIL rst_mid_lrclk: got %b want 0", lrclk); else passed++;
    checks++; if (sda !== 1'b0) $display("FAIL rst_mid_sda: got %b want 0", sda); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ready); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL rst_mid_underrun: got %b want 0", underrun); else passed++;
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i2s_stream();
    test_left_justified();
    test_tdm();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
